// File: rtl/jtopl_acc_pkg.sv
// ---------------------------------------------------------------------------
// jtopl_acc_pkg
// Shared constants for the OPL output accumulator: frame geometry, operator
// result width, default accumulator/sample widths and FSM state encoding.
// ---------------------------------------------------------------------------
package jtopl_acc_pkg;

    // Operator result width (signed, bit-inverted negatives used as-is)
    localparam int OPW      = 13;
    // Default accumulator width: 18 terms of 13 bits cannot overflow it
    localparam int ACCW_DEF = 18;
    // Default output sample width (signed)
    localparam int OUTW_DEF = 16;

    // Number of slots in one frame; the slot counter reaches this value
    // once every term of the frame has been accumulated.
    localparam logic [4:0] SLOTS = 5'd18;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/jtopl_acc_sat.sv
// ---------------------------------------------------------------------------
// jtopl_acc_sat
// Combinational saturator from the ACCW-bit signed accumulator to an
// OUTW-bit signed sample.
// Ports:
//   i_acc  in  ACCW  signed accumulator value
//   o_snd  out OUTW  saturated sample
//   o_clip out 1     high when i_acc lies outside the OUTW signed range
// ---------------------------------------------------------------------------
module jtopl_acc_sat #(
    parameter int ACCW = 18,
    parameter int OUTW = 16
) (
    input  logic [ACCW-1:0] i_acc,
    output logic [OUTW-1:0] o_snd,
    output logic            o_clip
);

    // The value fits in OUTW bits exactly when every bit from the OUTW sign
    // position upward equals the accumulator sign.
    logic [ACCW-OUTW:0] w_hi;
    logic               w_ovf;

    assign w_hi  = i_acc[ACCW-1:OUTW-1];
    assign w_ovf = !((&w_hi) || (~|w_hi));

    // Select the clamped extreme on overflow, otherwise pass the low bits
    always_comb begin
        o_snd  = i_acc[OUTW-1:0];
        o_clip = 1'b0;
        if (w_ovf) begin
            o_clip = 1'b1;
            if (i_acc[ACCW-1]) begin
                o_snd = {1'b1, {(OUTW-1){1'b0}}};
            end else begin
                o_snd = {1'b0, {(OUTW-1){1'b1}}};
            end
        end else begin
            o_clip = 1'b0;
        end
    end

endmodule

// File: rtl/jtopl_acc.sv
// ---------------------------------------------------------------------------
// jtopl_acc
// Output accumulator for the OPL operator pipeline. Sums every carrier
// contribution over an 18-slot frame and, at each frame boundary, presents
// the saturated sum with a one-clock valid strobe.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   cenop      in   operator clock enable; state advances only when high
//   zero       in   marks the cenop cycle carrying slot 0's result
//   op_result  in   13-bit signed operator output
//   op_out     in   slot is a carrier
//   con_out    in   additive connection for the slot's voice
//   snd        out  signed mixed sample, holds between frames
//   snd_valid  out  one-clock pulse when snd updates
//   clip       out  last reported frame saturated
//   sync_err   out  one-clock pulse on a framing error
// ---------------------------------------------------------------------------
module jtopl_acc
    import jtopl_acc_pkg::*;
#(
    parameter int ACCW = ACCW_DEF,
    parameter int OUTW = OUTW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cenop,
    input  logic            zero,
    input  logic [OPW-1:0]  op_result,
    input  logic            op_out,
    input  logic            con_out,
    output logic [OUTW-1:0] snd,
    output logic            snd_valid,
    output logic            clip,
    output logic            sync_err
);

    logic [0:0]      r_state;
    logic [ACCW-1:0] r_acc;
    logic [4:0]      r_slot;
    logic [OUTW-1:0] r_snd;
    logic            r_snd_valid;
    logic            r_clip;
    logic            r_sync_err;

    logic [0:0]      w_state_nx;
    logic [ACCW-1:0] w_acc_nx;
    logic [4:0]      w_slot_nx;
    logic            w_load;
    logic            w_valid_nx;
    logic            w_err_nx;
    logic [ACCW-1:0] w_term;
    logic [OUTW-1:0] w_sat;
    logic            w_sat_clip;

    // Modulator slots in FM mode contribute nothing to the mix
    assign w_term = (op_out | con_out) ?
                    {{(ACCW-OPW){op_result[OPW-1]}}, op_result} :
                    {ACCW{1'b0}};

    jtopl_acc_sat #(
        .ACCW (ACCW),
        .OUTW (OUTW)
    ) u_sat (
        .i_acc  (r_acc),
        .o_snd  (w_sat),
        .o_clip (w_sat_clip)
    );

    // Frame FSM: next state, accumulator, slot counter and event strobes
    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_slot_nx  = r_slot;
        w_load     = 1'b0;
        w_valid_nx = 1'b0;
        w_err_nx   = 1'b0;
        if (cenop) begin
            case (r_state)
                ST_IDLE: begin
                    // First zero only synchronises; no complete frame yet
                    if (zero) begin
                        w_state_nx = ST_RUN;
                        w_acc_nx   = w_term;
                        w_slot_nx  = 5'd1;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (zero) begin
                        // A zero after exactly 18 slots closes the frame;
                        // earlier it discards the partial frame.
                        if (r_slot == SLOTS) begin
                            w_load     = 1'b1;
                            w_valid_nx = 1'b1;
                        end else begin
                            w_err_nx   = 1'b1;
                        end
                        w_acc_nx  = w_term;
                        w_slot_nx = 5'd1;
                    end else if (r_slot == SLOTS) begin
                        // This cenop would be slot 18: zero went missing
                        w_err_nx   = 1'b1;
                        w_acc_nx   = {ACCW{1'b0}};
                        w_slot_nx  = 5'd0;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_acc_nx  = r_acc + w_term;
                        w_slot_nx = r_slot + 5'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_acc_nx   = {ACCW{1'b0}};
                    w_slot_nx  = 5'd0;
                end
            endcase
        end else begin
            w_state_nx = r_state;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= {ACCW{1'b0}};
            r_slot      <= 5'd0;
            r_snd       <= {OUTW{1'b0}};
            r_clip      <= 1'b0;
            r_snd_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_acc       <= w_acc_nx;
            r_slot      <= w_slot_nx;
            r_snd_valid <= w_valid_nx;
            r_sync_err  <= w_err_nx;
            if (w_load) begin
                r_snd  <= w_sat;
                r_clip <= w_sat_clip;
            end else begin
                r_snd  <= r_snd;
                r_clip <= r_clip;
            end
        end
    end

    assign snd       = r_snd;
    assign snd_valid = r_snd_valid;
    assign clip      = r_clip;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_jtopl_acc.sv
module tb_jtopl_acc;

    logic        clk;
    logic        rst;
    logic        cenop;
    logic        zero;
    logic [12:0] op_result;
    logic        op_out;
    logic        con_out;
    logic [15:0] snd;
    logic        snd_valid;
    logic        clip;
    logic        sync_err;

    int checks;
    int failures;
    int gap;

    // Observation after the most recent cenop edge
    logic [15:0] obs_snd;
    logic        obs_valid;
    logic        obs_clip;
    logic        obs_err;
    // Observation after the zero cenop of the most recent frame
    logic [15:0] f_snd;
    logic        f_valid;
    logic        f_clip;
    logic        f_err;
    // Any strobe seen on later cenops of the frame, or on idle gap cycles
    logic        mid_pulse;
    logic        gap_pulse;

    jtopl_acc dut (
        .clk       (clk),
        .rst       (rst),
        .cenop     (cenop),
        .zero      (zero),
        .op_result (op_result),
        .op_out    (op_out),
        .con_out   (con_out),
        .snd       (snd),
        .snd_valid (snd_valid),
        .clip      (clip),
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cenop cycle, followed by `gap` cycles with cenop low
    task automatic cen(input logic z, input logic [12:0] v, input logic o, input logic c);
        cenop = 1'b1; zero = z; op_result = v; op_out = o; con_out = c;
        @(posedge clk); #1;
        obs_snd = snd; obs_valid = snd_valid; obs_clip = clip; obs_err = sync_err;
        cenop = 1'b0; zero = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            if (snd_valid || sync_err) gap_pulse = 1'b1;
        end
    endtask

    // n cenops starting with zero; slot i is a carrier when om[i] is set
    task automatic send(input logic [12:0] v, input logic [17:0] om, input logic cm, input int n);
        mid_pulse = 1'b0;
        for (int i = 0; i < n; i++) begin
            cen(i == 0, v, om[i], cm);
            if (i == 0) begin
                f_snd = obs_snd; f_valid = obs_valid; f_clip = obs_clip; f_err = obs_err;
            end else if (obs_valid || obs_err) begin
                mid_pulse = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cenop = 1'b0; zero = 1'b0; op_result = 13'd0; op_out = 1'b0; con_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (snd !== 16'h0000) begin failures++; $display("FAIL reset_snd got=%h exp=0000", snd); end
        checks++; if (snd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", snd_valid); end
        checks++; if (clip !== 1'b0) begin failures++; $display("FAIL reset_clip got=%b exp=0", clip); end
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", sync_err); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        send(13'd100, 18'h3FFFF, 1'b0, 18);
        checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL first_zero_valid got=%b exp=0", f_valid); end
        // Modulator-only slots at 4095 contribute nothing
        send(13'h0FFF, 18'h00000, 1'b0, 18);
        checks++; if (f_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", f_valid); end
        checks++; if (f_snd !== 16'd1800) begin failures++; $display("FAIL basic_snd got=%0d exp=1800", f_snd); end
        checks++; if (f_clip !== 1'b0) begin failures++; $display("FAIL basic_clip got=%b exp=0", f_clip); end
        checks++; if (mid_pulse !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", mid_pulse); end
    endtask

    task automatic test_carrier_mask;
        // Nine carrier slots at -50
        send(13'h1FCE, 18'h15555, 1'b0, 18);
        checks++; if (f_snd !== 16'h0000) begin failures++; $display("FAIL modulator_snd got=%h exp=0000", f_snd); end
        send(13'h0FFF, 18'h3FFFF, 1'b0, 18);
        checks++; if (f_snd !== 16'hFE3E) begin failures++; $display("FAIL mask_snd got=%h exp=fe3e", f_snd); end
        checks++; if (f_valid !== 1'b1) begin failures++; $display("FAIL mask_valid got=%b exp=1", f_valid); end
    endtask

    task automatic test_saturation;
        // -4096 on every slot via the connection flag only
        send(13'h1000, 18'h00000, 1'b1, 18);
        checks++; if (f_snd !== 16'h7FFF) begin failures++; $display("FAIL sat_pos_snd got=%h exp=7fff", f_snd); end
        checks++; if (f_clip !== 1'b1) begin failures++; $display("FAIL sat_pos_clip got=%b exp=1", f_clip); end
        send(13'd0, 18'h3FFFF, 1'b0, 18);
        checks++; if (f_snd !== 16'h8000) begin failures++; $display("FAIL sat_neg_snd got=%h exp=8000", f_snd); end
        checks++; if (f_clip !== 1'b1) begin failures++; $display("FAIL sat_neg_clip got=%b exp=1", f_clip); end
        send(13'd7, 18'h3FFFF, 1'b0, 18);
        checks++; if ((f_snd !== 16'h0000) || (f_clip !== 1'b0)) begin failures++; $display("FAIL sat_clear got=%h/%b exp=0000/0", f_snd, f_clip); end
    endtask

    task automatic test_early_zero;
        // Frame of 7s closes here; then a frame cut short after 10 slots
        send(13'd10, 18'h3FFFF, 1'b0, 10);
        checks++; if (f_snd !== 16'd126) begin failures++; $display("FAIL pre_early_snd got=%0d exp=126", f_snd); end
        send(13'd20, 18'h3FFFF, 1'b0, 18);
        checks++; if (f_err !== 1'b1) begin failures++; $display("FAIL early_err got=%b exp=1", f_err); end
        checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL early_valid got=%b exp=0", f_valid); end
        checks++; if (f_snd !== 16'd126) begin failures++; $display("FAIL early_hold got=%0d exp=126", f_snd); end
        checks++; if (mid_pulse !== 1'b0) begin failures++; $display("FAIL early_err_width got=%b exp=0", mid_pulse); end
        send(13'd5, 18'h3FFFF, 1'b0, 18);
        checks++; if ((f_valid !== 1'b1) || (f_snd !== 16'd360)) begin failures++; $display("FAIL early_recover got=%b/%0d exp=1/360", f_valid, f_snd); end
    endtask

    task automatic test_missing_zero;
        cen(1'b0, 13'd5, 1'b1, 1'b0);
        checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL missing_err got=%b exp=1", obs_err); end
        checks++; if ((obs_valid !== 1'b0) || (obs_snd !== 16'd360)) begin failures++; $display("FAIL missing_hold got=%b/%0d exp=0/360", obs_valid, obs_snd); end
        cen(1'b0, 13'd5, 1'b1, 1'b0);
        checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL idle_err got=%b exp=0", obs_err); end
        send(13'd3, 18'h3FFFF, 1'b0, 18);
        checks++; if ((f_valid !== 1'b0) || (f_err !== 1'b0)) begin failures++; $display("FAIL resync got=%b/%b exp=0/0", f_valid, f_err); end
        send(13'd9, 18'h3FFFF, 1'b0, 18);
        checks++; if ((f_valid !== 1'b1) || (f_snd !== 16'd54)) begin failures++; $display("FAIL resync_frame got=%b/%0d exp=1/54", f_valid, f_snd); end
    endtask

    task automatic test_gap_reset;
        gap = 3;
        gap_pulse = 1'b0;
        send(13'd2, 18'h3FFFF, 1'b0, 18);
        checks++; if ((f_valid !== 1'b1) || (f_snd !== 16'd162)) begin failures++; $display("FAIL gap_frame got=%b/%0d exp=1/162", f_valid, f_snd); end
        checks++; if ((gap_pulse !== 1'b0) || (mid_pulse !== 1'b0)) begin failures++; $display("FAIL gap_pulse got=%b/%b exp=0/0", gap_pulse, mid_pulse); end
        send(13'd1, 18'h3FFFF, 1'b0, 5);
        checks++; if (f_snd !== 16'd36) begin failures++; $display("FAIL gap_sum got=%0d exp=36", f_snd); end
        // Reset between clock edges must clear outputs immediately
        #2 rst = 1'b1;
        #1;
        checks++; if ((snd !== 16'h0000) || (clip !== 1'b0) || (snd_valid !== 1'b0) || (sync_err !== 1'b0)) begin
            failures++; $display("FAIL async_reset got=%h/%b/%b/%b exp=0000/0/0/0", snd, clip, snd_valid, sync_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send(13'd2, 18'h3FFFF, 1'b0, 18);
        checks++; if ((f_valid !== 1'b0) || (f_snd !== 16'h0000)) begin failures++; $display("FAIL post_reset_sync got=%b/%0d exp=0/0", f_valid, f_snd); end
        send(13'd0, 18'h3FFFF, 1'b0, 18);
        checks++; if ((f_valid !== 1'b1) || (f_snd !== 16'd36)) begin failures++; $display("FAIL post_reset_frame got=%b/%0d exp=1/36", f_valid, f_snd); end
        gap = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        gap = 0;
        gap_pulse = 1'b0;
        mid_pulse = 1'b0;
        test_reset;
        test_basic;
        test_carrier_mask;
        test_saturation;
        test_early_zero;
        test_missing_zero;
        test_gap_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtopl_acc.md
# jtopl_acc

Output accumulator for the OPL operator pipeline: consumes the per-slot operator output stream (13-bit result plus the delayed op/connection flags) and sums every carrier contribution over one 18-slot frame. At each frame boundary it saturates the sum to a signed sample and presents it with a one-cycle valid strobe. It sits directly downstream of the operator stage and feeds the sound output / DAC interface.

## Interface
- ACCW, 18: accumulator width; holds 18 × 13-bit terms without overflow.
- OUTW, 16: sample width, signed.
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- cenop  in  1  operator clock enable; all state advances only when high.
- zero  in  1  high on the cenop cycle whose op_result belongs to slot 0; the top level aligns it to the operator output.
- op_result  in  13  signed operator output (bit-inverted negative, no +1 correction; treated as plain signed).
- op_out  in  1  slot is a carrier (op=1), aligned with op_result.
- con_out  in  1  additive connection for the slot's voice, aligned with op_result.
- snd  out  OUTW  signed mixed sample, holds between frames.
- snd_valid  out  1  one-clk pulse (on a cenop cycle) when snd updates.
- clip  out  1  high with snd when the last frame saturated; holds with snd.
- sync_err  out  1  one-clk pulse on a framing error.

## Operation
- term = (op_out | con_out) ? sign-extend(op_result) to ACCW : 0. Modulator slots in FM mode contribute nothing.
- Slot counter slot[4:0], 0..17, advances on each cenop; loaded to 1 when zero is seen.
- FSM, two states:
  - IDLE (reset state): acc and output unchanged; on cenop with zero → RUN, acc ← term, slot ← 1. No snd_valid (no complete frame yet).
  - RUN: on cenop:
    - zero and slot==18-wrap point (slot==0 after 17 → i.e. 18 slots elapsed): frame complete; snd ← sat(acc), clip ← (acc out of OUTW range), snd_valid pulse, acc ← term, slot ← 1.
    - zero at any other slot: early frame; sync_err pulse, frame discarded (snd unchanged), acc ← term, slot ← 1, stay RUN.
    - no zero and slot==17 already passed (18 slots without zero): sync_err pulse, acc ← 0, → IDLE.
    - otherwise acc ← acc + term, slot ← slot+1.
- Saturation: acc > 2^(OUTW-1)-1 → 0x7FFF; acc < -2^(OUTW-1) → 0x8000; else low OUTW bits.
- Missing zero is detected on the cenop cycle that would be slot 18.

## Timing
- Reset values: snd=0, snd_valid=0, clip=0, sync_err=0, acc=0, slot=0, state IDLE.
- Latency: slot-0 input of frame N+1 (zero) coincides with snd/snd_valid registering frame N; outputs visible the clk after that cenop.
- snd_valid and sync_err are registered, exactly one clk wide, even if cenop stays high continuously; both low when cenop low.
- Reset asserted mid-frame: immediate return to reset values; first zero after release only synchronises (no snd_valid).
- cenop low: no state change, inputs ignored.

## Structure
- Shared package constants: slot count (18), OPW (13), ACCW/OUTW defaults, FSM state encoding.
- One natural sub-module: jtopl_acc_sat (combinational ACCW→OUTW saturator returning value and clip flag); rest in jtopl_acc.

## Test plan
- Reset then zero every 18 cenops, all slots op_out=1, op_result=100 → first zero no valid; next zero snd=1800, clip=0, snd_valid one clk.
- op_out=0, con_out=0 on all slots, op_result=4095 → snd=0 each frame; only op_out=1 slots (9 of 18) at −50 → snd=−450.
- All 18 slots carrier, op_result=4095 → acc=73710, snd=0x7FFF, clip=1; all −4096 → snd=0x8000, clip=1.
- zero at slot 10 → sync_err pulse, no snd_valid, snd holds prior value; next regular frame outputs correct sum.
- zero withheld for 19 cenops → sync_err at slot 18, state IDLE; next zero resyncs without snd_valid.
- cenop toggled 1-in-4 with rst asserted mid-frame → all outputs 0 asynchronously; sums after release identical to continuous-cenop run.
